// File: rtl/ras_ckpt_pkg.sv
// Shared core package: return-address-stack checkpoint type, sizing helpers
// and the per-cycle command decode used by ras_ckpt.
package ras_ckpt_pkg;

  localparam int RAS_DEPTH = 2;
  localparam int RAS_VLEN  = 64;

  function automatic int ras_ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int RAS_PTRW = ras_ptr_w(RAS_DEPTH);
  localparam int RAS_CNTW = ras_cnt_w(RAS_DEPTH);

  typedef struct packed {
    logic [RAS_PTRW-1:0] ptr;
    logic [RAS_CNTW-1:0] cnt;
    logic [RAS_VLEN-1:0] top;
  } ras_ckpt_t;

  // REPLACE is push+pop on a non-empty stack: rewrite the top in place.
  typedef enum logic [2:0] {
    RAS_IDLE,
    RAS_FLUSH,
    RAS_RESTORE,
    RAS_PUSH,
    RAS_POP,
    RAS_REPLACE
  } ras_op_e;

  function automatic ras_op_e ras_decode(input logic flush, input logic restore,
                                         input logic push, input logic pop,
                                         input logic empty);
    if (flush)        return RAS_FLUSH;
    if (restore)      return RAS_RESTORE;
    if (push && pop)  return empty ? RAS_PUSH : RAS_REPLACE;
    if (push)         return RAS_PUSH;
    if (pop)          return RAS_POP;
    return RAS_IDLE;
  endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Checkpointable return address stack: circular flip-flop storage with
// overwrite-oldest on overflow and single-cycle checkpoint restore.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int  DEPTH  = RAS_DEPTH,
  parameter int  VLEN   = RAS_VLEN,
  parameter type ckpt_t = ras_ckpt_t
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [VLEN-1:0] push_addr_i,
  input  logic            pop_i,
  input  logic            restore_i,
  input  ckpt_t           restore_ckpt_i,
  output ckpt_t           ckpt_o,
  output logic            top_valid_o,
  output logic [VLEN-1:0] top_addr_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int PTRW = ras_ptr_w(DEPTH);
  localparam int CNTW = ras_cnt_w(DEPTH);

  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
  localparam logic [PTRW:0]   PTR_LIM  = (PTRW + 1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  typedef struct packed {
    logic [PTRW-1:0] ptr;
    logic [CNTW-1:0] cnt;
    logic [VLEN-1:0] top;
  } ckpt_local_t;

  logic [VLEN-1:0] r_mem [DEPTH];
  logic [PTRW-1:0] r_tos;
  logic [CNTW-1:0] r_cnt;
  logic            r_overflow;
  logic            r_underflow;

  ckpt_local_t     w_restore;
  ckpt_local_t     w_ckpt;
  ras_op_e         w_op;
  logic            w_empty;
  logic            w_full;
  logic [PTRW-1:0] w_tos_inc;
  logic [PTRW-1:0] w_tos_dec;
  logic [PTRW-1:0] w_rptr;
  logic [CNTW-1:0] w_rcnt;
  logic [PTRW-1:0] w_tos_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_we;
  logic [PTRW-1:0] w_waddr;
  logic [VLEN-1:0] w_wdata;
  logic            w_ovf_nxt;
  logic            w_udf_nxt;
  logic [VLEN-1:0] w_top_entry;

  assign w_restore = ckpt_local_t'(restore_ckpt_i);

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_FULL);
  assign w_tos_inc = (r_tos == PTR_LAST) ? '0 : r_tos + PTRW'(1);
  assign w_tos_dec = (r_tos == '0) ? PTR_LAST : r_tos - PTRW'(1);

  // A checkpoint pointer can encode values >= DEPTH when DEPTH is not a power
  // of two; fold it back so the storage index always stays in range.
  assign w_rptr = ({1'b0, w_restore.ptr} >= PTR_LIM) ? w_restore.ptr - PTR_LIM[PTRW-1:0]
                                                     : w_restore.ptr;
  assign w_rcnt = (w_restore.cnt > CNT_FULL) ? CNT_FULL : w_restore.cnt;

  assign w_op = ras_decode(flush_i, restore_i, push_i, pop_i, w_empty);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_cnt;
    w_we      = 1'b0;
    w_waddr   = r_tos;
    w_wdata   = push_addr_i;
    w_ovf_nxt = 1'b0;
    w_udf_nxt = 1'b0;
    unique case (w_op)
      RAS_FLUSH: begin
        w_tos_nxt = '0;
        w_cnt_nxt = '0;
      end
      RAS_RESTORE: begin
        w_tos_nxt = w_rptr;
        w_cnt_nxt = w_rcnt;
        w_we      = 1'b1;
        w_waddr   = w_rptr;
        w_wdata   = w_restore.top;
      end
      RAS_PUSH: begin
        w_tos_nxt = w_tos_inc;
        w_cnt_nxt = w_full ? r_cnt : r_cnt + CNTW'(1);
        w_we      = 1'b1;
        w_waddr   = w_tos_inc;
        w_ovf_nxt = w_full;
      end
      RAS_POP: begin
        if (w_empty) begin
          w_udf_nxt = 1'b1;
        end else begin
          w_tos_nxt = w_tos_dec;
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
      RAS_REPLACE: begin
        w_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tos       <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      // NOTE: the storage is cleared on reset so the top/checkpoint outputs
      // read zero afterwards; flush deliberately leaves the entries intact.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register updates from
      // the same pre-edge values regardless of statement order.
      r_tos       <= w_tos_nxt;
      r_cnt       <= w_cnt_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_udf_nxt;
      if (w_we) r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_top_entry = r_mem[r_tos];
  assign top_valid_o = ~w_empty;
  assign top_addr_o  = w_empty ? '0 : w_top_entry;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

  assign w_ckpt = '{ptr: r_tos, cnt: r_cnt, top: w_top_entry};
  assign ckpt_o = ckpt_t'(w_ckpt);

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: a DEPTH=4 instance for the main scenarios and
// a DEPTH=3 instance for non-power-of-two pointer wrap.
module tb_ras_ckpt;

  typedef struct packed {
    logic [1:0]  ptr;
    logic [2:0]  cnt;
    logic [63:0] top;
  } ckpt4_t;

  typedef struct packed {
    logic [1:0]  ptr;
    logic [1:0]  cnt;
    logic [63:0] top;
  } ckpt3_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        a_rst, a_flush, a_push, a_pop, a_restore;
  logic [63:0] a_addr;
  ckpt4_t      a_rckpt, a_ckpt, saved;
  logic        a_valid, a_ovf, a_udf;
  logic [63:0] a_top;

  logic        b_rst, b_flush, b_push, b_pop, b_restore;
  logic [63:0] b_addr;
  ckpt3_t      b_rckpt, b_ckpt;
  logic        b_valid, b_ovf, b_udf;
  logic [63:0] b_top;

  ras_ckpt #(.DEPTH(4), .VLEN(64), .ckpt_t(ckpt4_t)) u_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .push_i(a_push),
    .push_addr_i(a_addr), .pop_i(a_pop), .restore_i(a_restore),
    .restore_ckpt_i(a_rckpt), .ckpt_o(a_ckpt), .top_valid_o(a_valid),
    .top_addr_o(a_top), .overflow_o(a_ovf), .underflow_o(a_udf)
  );

  ras_ckpt #(.DEPTH(3), .VLEN(64), .ckpt_t(ckpt3_t)) u_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .push_i(b_push),
    .push_addr_i(b_addr), .pop_i(b_pop), .restore_i(b_restore),
    .restore_ckpt_i(b_rckpt), .ckpt_o(b_ckpt), .top_valid_o(b_valid),
    .top_addr_o(b_top), .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_rst = 0; a_flush = 0; a_push = 0; a_pop = 0; a_restore = 0;
    a_addr = '0; a_rckpt = '0;
  endtask

  task automatic b_idle();
    b_rst = 0; b_flush = 0; b_push = 0; b_pop = 0; b_restore = 0;
    b_addr = '0; b_rckpt = '0;
  endtask

  task automatic a_op(input logic rst, input logic flush, input logic restore,
                      input ckpt4_t ck, input logic push, input logic pop,
                      input logic [63:0] addr);
    a_rst = rst; a_flush = flush; a_restore = restore; a_rckpt = ck;
    a_push = push; a_pop = pop; a_addr = addr;
    tick();
    a_idle();
  endtask

  task automatic b_op(input logic rst, input logic restore, input ckpt3_t ck,
                      input logic push, input logic pop, input logic [63:0] addr);
    b_rst = rst; b_restore = restore; b_rckpt = ck;
    b_push = push; b_pop = pop; b_addr = addr;
    tick();
    b_idle();
  endtask

  initial begin
    a_idle();
    b_idle();
    tick();

    // Reset state
    a_op(1, 0, 0, '0, 0, 0, 64'h0);
    chk("rst_valid", a_valid, 0);
    chk("rst_top", a_top, 0);
    chk("rst_ptr", a_ckpt.ptr, 0);
    chk("rst_cnt", a_ckpt.cnt, 0);
    chk("rst_ckpt_top", a_ckpt.top, 0);

    // Basic push/pop
    a_op(0, 0, 0, '0, 1, 0, 64'h100);
    a_op(0, 0, 0, '0, 1, 0, 64'h200);
    chk("push2_top", a_top, 64'h200);
    chk("push2_cnt", a_ckpt.cnt, 2);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("pop_top", a_top, 64'h100);
    chk("pop_cnt", a_ckpt.cnt, 1);

    // Overflow: fifth push discards 0x10
    a_op(1, 0, 0, '0, 0, 0, 64'h0);
    for (int i = 1; i <= 4; i++) a_op(0, 0, 0, '0, 1, 0, 64'(i * 16));
    chk("ovf_before", a_ovf, 0);
    a_op(0, 0, 0, '0, 1, 0, 64'h50);
    chk("ovf_pulse", a_ovf, 1);
    chk("ovf_cnt", a_ckpt.cnt, 4);
    chk("ovf_top0", a_top, 64'h50);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("ovf_end", a_ovf, 0);
    chk("ovf_top1", a_top, 64'h40);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("ovf_top2", a_top, 64'h30);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("ovf_top3", a_top, 64'h20);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("ovf_cnt_end", a_ckpt.cnt, 0);
    chk("ovf_valid_end", a_valid, 0);
    chk("ovf_top_end", a_top, 0);

    // Underflow on empty stack (tos sits at 1 after the pops above)
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("udf_pulse", a_udf, 1);
    chk("udf_cnt", a_ckpt.cnt, 0);
    chk("udf_ptr", a_ckpt.ptr, 1);
    chk("udf_valid", a_valid, 0);
    tick();
    chk("udf_end", a_udf, 0);
    a_op(0, 0, 0, '0, 1, 1, 64'hA0);
    chk("pp_empty_cnt", a_ckpt.cnt, 1);
    chk("pp_empty_top", a_top, 64'hA0);
    chk("pp_empty_udf", a_udf, 0);

    // Checkpoint/restore; the checkpoint only carries the top entry, so the
    // entry below keeps the value written by the wrong-path push+pop.
    a_op(1, 0, 0, '0, 0, 0, 64'h0);
    a_op(0, 0, 0, '0, 1, 0, 64'h1);
    a_op(0, 0, 0, '0, 1, 0, 64'h2);
    saved = a_ckpt;
    chk("cap_ptr", saved.ptr, 2);
    chk("cap_cnt", saved.cnt, 2);
    chk("cap_top", saved.top, 64'h2);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("wp_pop_top", a_top, 64'h1);
    a_op(0, 0, 0, '0, 1, 1, 64'h9);
    chk("wp_pp_top", a_top, 64'h9);
    chk("wp_pp_cnt", a_ckpt.cnt, 1);
    a_op(0, 0, 1, saved, 0, 0, 64'h0);
    chk("rs_top", a_top, 64'h2);
    chk("rs_cnt", a_ckpt.cnt, 2);
    chk("rs_ptr", a_ckpt.ptr, 2);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("rs_pop_top", a_top, 64'h9);
    chk("rs_pop_cnt", a_ckpt.cnt, 1);

    // Restore clamps an oversized count
    a_op(0, 0, 1, '{ptr: 2'd3, cnt: 3'd7, top: 64'hBEEF}, 0, 0, 64'h0);
    chk("clamp_cnt", a_ckpt.cnt, 4);
    chk("clamp_ptr", a_ckpt.ptr, 3);
    chk("clamp_top", a_top, 64'hBEEF);

    // Priority: flush wins over restore and push
    a_op(0, 1, 1, saved, 1, 0, 64'h77);
    chk("prio_cnt", a_ckpt.cnt, 0);
    chk("prio_valid", a_valid, 0);
    chk("prio_ptr", a_ckpt.ptr, 0);

    // Reset wins over push and clears pending pulses
    a_op(0, 0, 0, '0, 1, 0, 64'h33);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    a_op(0, 0, 0, '0, 0, 1, 64'h0);
    chk("pre_rst_udf", a_udf, 1);
    a_op(1, 0, 0, '0, 1, 0, 64'h44);
    chk("rstp_valid", a_valid, 0);
    chk("rstp_top", a_top, 0);
    chk("rstp_ptr", a_ckpt.ptr, 0);
    chk("rstp_cnt", a_ckpt.cnt, 0);
    chk("rstp_ckpt_top", a_ckpt.top, 0);
    chk("rstp_udf", a_udf, 0);
    chk("rstp_ovf", a_ovf, 0);

    // DEPTH=3: pushes wrap tos 2->0, pops wrap 0->2
    b_op(1, 0, '0, 0, 0, 64'h0);
    for (int i = 1; i <= 3; i++) b_op(0, 0, '0, 1, 0, 64'(i * 17));
    chk("d3_ovf_none", b_ovf, 0);
    chk("d3_ptr3", b_ckpt.ptr, 0);
    b_op(0, 0, '0, 1, 0, 64'h44);
    chk("d3_ovf_pulse", b_ovf, 1);
    b_op(0, 0, '0, 1, 0, 64'h55);
    b_op(0, 0, '0, 1, 0, 64'h66);
    chk("d3_top6", b_top, 64'h66);
    chk("d3_cnt6", b_ckpt.cnt, 3);
    chk("d3_ptr6", b_ckpt.ptr, 0);
    b_op(0, 0, '0, 0, 1, 64'h0);
    chk("d3_pop1_top", b_top, 64'h55);
    chk("d3_pop1_ptr", b_ckpt.ptr, 2);
    b_op(0, 0, '0, 0, 1, 64'h0);
    chk("d3_pop2_top", b_top, 64'h44);
    b_op(0, 0, '0, 0, 1, 64'h0);
    chk("d3_pop3_cnt", b_ckpt.cnt, 0);
    chk("d3_pop3_valid", b_valid, 0);

    // DEPTH=3: out-of-range checkpoint pointer folds back into range
    b_op(0, 1, '{ptr: 2'd3, cnt: 2'd3, top: 64'hCC}, 0, 0, 64'h0);
    chk("d3_rs_ptr", b_ckpt.ptr, 0);
    chk("d3_rs_cnt", b_ckpt.cnt, 3);
    chk("d3_rs_top", b_top, 64'hCC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
